layer1_fmap_buffer: RTL and testbench

LAYER1_FMAP_BUFFER -- requirements
Module: layer1_fmap_buffer

---
 rtl/lenet_pkg.sv | 14 +
 rtl/fmap_bank.sv | 37 +++
 rtl/layer1_fmap_buffer.sv | 199 +++++++++++++++++++
 tb/tb_layer1_fmap_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared LeNet constants and the layer-1 feature-map buffer state type.
package lenet_pkg;

  localparam int NUM_CH     = 6;
  localparam int L1_MAPSIZE = 14;
  localparam int L1_PIXELS  = L1_MAPSIZE * L1_MAPSIZE;
  localparam int DATA_W     = 8;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } fmap_state_e;

endpackage

// File: rtl/fmap_bank.sv
// Single-channel feature-map store: one write port, one registered read port.
module fmap_bank #(
  parameter int DEPTH  = lenet_pkg::L1_PIXELS,
  parameter int DATA_W = lenet_pkg::DATA_W,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately left unreset; only the read register clears.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/layer1_fmap_buffer.sv
// Captures NUM_CH pooled layer-1 maps in parallel, then serializes them
// channel-major over a valid/ready stream.
module layer1_fmap_buffer #(
  parameter int NUM_CH  = lenet_pkg::NUM_CH,
  parameter int MAPSIZE = lenet_pkg::L1_MAPSIZE,
  parameter int DATA_W  = lenet_pkg::DATA_W,
  localparam int PIXELS = MAPSIZE * MAPSIZE,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int IDX_W  = $clog2(PIXELS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        data_valid_in,
  input  logic [NUM_CH*DATA_W-1:0] pixel_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_last,
  output logic                     frame_done,
  output logic                     overflow
);

  import lenet_pkg::*;

  localparam int PTR_W = $clog2(PIXELS + 1);
  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(PIXELS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIXELS - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

  fmap_state_e state_q, state_d;

  logic [PTR_W-1:0] wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0] wr_ptr_d [NUM_CH];
  logic [CH_W-1:0]  rd_ch_q, rd_ch_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic             fetch_done_q, fetch_done_d;

  logic             valid_q, valid_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;
  logic             frame_done_q, frame_done_d;
  logic             overflow_q, overflow_d;

  logic [NUM_CH-1:0] ch_full;
  logic [NUM_CH-1:0] bank_we;
  logic [DATA_W-1:0] bank_rdata [NUM_CH];
  logic              all_full;
  logic              fire;
  logic              load;

  always_comb begin
    ch_full = '0;
    bank_we = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      ch_full[c] = (wr_ptr_q[c] == PTR_FULL);
      bank_we[c] = (state_q == FILL) && data_valid_in[c] && !ch_full[c];
    end
  end

  assign all_full = &ch_full;
  assign fire     = valid_q && out_ready;
  // Fetching a new beat also advances the banks' read registers, so it only
  // happens when the output slot is empty or being emptied this cycle.
  assign load     = (state_q == DRAIN) && !fetch_done_q && (!valid_q || out_ready);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_bank
    fmap_bank #(
      .DEPTH (PIXELS),
      .DATA_W(DATA_W),
      .AW    (IDX_W)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .we_i   (bank_we[c]),
      .waddr_i(IDX_W'(wr_ptr_q[c])),
      .wdata_i(pixel_in[c*DATA_W +: DATA_W]),
      .re_i   (load),
      .raddr_i(rd_idx_q),
      .rdata_o(bank_rdata[c])
    );
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ch_d      = rd_ch_q;
    rd_idx_d     = rd_idx_q;
    fetch_done_d = fetch_done_q;
    valid_d      = valid_q;
    ch_d         = ch_q;
    idx_d        = idx_q;
    last_d       = last_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;

    case (state_q)
      FILL: begin
        if (|(data_valid_in & ch_full)) begin
          overflow_d = 1'b1;
        end
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if (bank_we[c]) begin
            wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(1);
          end
        end
        rd_ch_d      = '0;
        rd_idx_d     = '0;
        fetch_done_d = 1'b0;
        if (all_full) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (|data_valid_in) begin
          overflow_d = 1'b1;
        end
        if (load) begin
          valid_d = 1'b1;
          ch_d    = rd_ch_q;
          idx_d   = rd_idx_q;
          last_d  = (rd_ch_q == CH_LAST) && (rd_idx_q == IDX_LAST);
          if (rd_idx_q == IDX_LAST) begin
            rd_idx_d = '0;
            if (rd_ch_q == CH_LAST) begin
              fetch_done_d = 1'b1;
            end else begin
              rd_ch_d = rd_ch_q + CH_W'(1);
            end
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end else if (fire) begin
          valid_d = 1'b0;
        end
        if (fire && last_q) begin
          state_d      = FILL;
          valid_d      = 1'b0;
          last_d       = 1'b0;
          frame_done_d = 1'b1;
          fetch_done_d = 1'b0;
          rd_ch_d      = '0;
          rd_idx_d     = '0;
          for (int unsigned c = 0; c < NUM_CH; c++) begin
            wr_ptr_d[c] = '0;
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      rd_ch_q      <= '0;
      rd_idx_q     <= '0;
      fetch_done_q <= 1'b0;
      valid_q      <= 1'b0;
      ch_q         <= '0;
      idx_q        <= '0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
      end
    end else begin
      state_q      <= state_d;
      rd_ch_q      <= rd_ch_d;
      rd_idx_q     <= rd_idx_d;
      fetch_done_q <= fetch_done_d;
      valid_q      <= valid_d;
      ch_q         <= ch_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
      end
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = bank_rdata[ch_q];
  assign out_ch     = ch_q;
  assign out_idx    = idx_q;
  assign out_last   = last_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_layer1_fmap_buffer.sv
// Directed bench for layer1_fmap_buffer: capture timing, drain order,
// back-pressure, overflow, mid-frame reset and signed extremes.
module tb_layer1_fmap_buffer;

  localparam int NCH   = 6;
  localparam int PIX   = 196;
  localparam int TOTAL = NCH * PIX;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   data_valid_in;
  logic [NCH*8-1:0] pixel_in;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic [2:0]       out_ch;
  logic [7:0]       out_idx;
  logic             out_last;
  logic             frame_done;
  logic             overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int start_off [NCH];
  int extra0_t  = -1;
  bit edge_vals = 1'b0;

  always #5 clk = ~clk;

  layer1_fmap_buffer #(
    .NUM_CH (6),
    .MAPSIZE(14),
    .DATA_W (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_valid_in(data_valid_in),
    .pixel_in     (pixel_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_ch       (out_ch),
    .out_idx      (out_idx),
    .out_last     (out_last),
    .frame_done   (frame_done),
    .overflow     (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int c, input int i);
    if (edge_vals && c == 5 && i == 0)   return 8'h80;
    if (edge_vals && c == 5 && i == 195) return 8'h7F;
    return 8'((c * 37 + i) % 256);
  endfunction

  function automatic logic [31:0] exp_beat(input int b);
    int c;
    int i;
    c = b / PIX;
    i = b % PIX;
    return {12'd0, pix(c, i), 3'(c), 8'(i), (b == TOTAL - 1)};
  endfunction

  function automatic logic [31:0] all_outs();
    return {9'd0, out_valid, out_data, out_ch, out_idx, out_last, frame_done, overflow};
  endfunction

  // Feeds every channel from its start offset; returns just after the last edge.
  task automatic stream();
    int  tend;
    bit  early;
    tend  = extra0_t;
    early = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (start_off[c] + PIX - 1 > tend) tend = start_off[c] + PIX - 1;
    end
    for (int t = 0; t <= tend; t++) begin
      for (int c = 0; c < NCH; c++) begin
        if (t >= start_off[c] && t < start_off[c] + PIX) begin
          data_valid_in[c]     = 1'b1;
          pixel_in[c*8 +: 8]   = pix(c, t - start_off[c]);
        end else begin
          data_valid_in[c]     = 1'b0;
          pixel_in[c*8 +: 8]   = 8'hAA;
        end
      end
      if (t == extra0_t) begin
        data_valid_in[0] = 1'b1;
        pixel_in[7:0]    = 8'h55;
      end
      if (out_valid) early = 1'b1;
      tick();
    end
    data_valid_in = '0;
    chk("no_valid_during_fill", {31'd0, early}, 32'd0);
  endtask

  task automatic check_latency();
    tick();
    chk("valid_at_n1", {31'd0, out_valid}, 32'd0);
    tick();
    chk("valid_at_n2", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic drain(input bit rnd, input int stop_at, input int strobe_at);
    int          beat;
    int          cyc;
    int          first;
    bit          stalled;
    logic [31:0] snap;
    beat    = 0;
    cyc     = 0;
    first   = -1;
    stalled = 1'b0;
    snap    = '0;
    while (beat < TOTAL && cyc < 5000 && !(stop_at >= 0 && beat == stop_at)) begin
      if (stalled)
        chk("stall_hold", {12'd0, out_data, out_ch, out_idx, out_last}, snap);
      if (beat > 0)
        chk("valid_mid_frame", {31'd0, out_valid}, 32'd1);
      if (out_valid) begin
        if (first < 0) first = cyc;
        chk("beat", {12'd0, out_data, out_ch, out_idx, out_last}, exp_beat(beat));
      end
      out_ready     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      data_valid_in = (beat == strobe_at) ? '1 : '0;
      stalled       = out_valid && !out_ready;
      snap          = {12'd0, out_data, out_ch, out_idx, out_last};
      if (out_valid && out_ready) beat++;
      tick();
      cyc++;
    end
    data_valid_in = '0;
    if (stop_at < 0) begin
      chk("beat_count", 32'(beat), 32'(TOTAL));
      chk("done_after_last", {30'd0, frame_done, out_valid}, 32'b10);
      if (!rnd) chk("throughput_cycles", 32'(cyc - first), 32'(TOTAL));
      tick();
      chk("done_one_cycle", {31'd0, frame_done}, 32'd0);
    end else begin
      chk("stop_beat_reached", 32'(beat), 32'(stop_at));
    end
  endtask

  initial begin
    bit saw_valid;
    rst           = 1'b1;
    data_valid_in = '0;
    pixel_in      = '0;
    out_ready     = 1'b0;
    for (int c = 0; c < NCH; c++) start_off[c] = 0;
    repeat (3) tick();
    chk("reset_outputs", all_outs(), 32'd0);
    rst = 1'b0;
    tick();

    // Lockstep frame, ready held high.
    out_ready = 1'b1;
    stream();
    check_latency();
    drain(1'b0, -1, -1);
    chk("ovf_clean_frame", {31'd0, overflow}, 32'd0);

    // Channel 3 late by 50 cycles; random back-pressure; strobe during drain.
    start_off[3] = 50;
    stream();
    check_latency();
    chk("ovf_before_drain", {31'd0, overflow}, 32'd0);
    drain(1'b1, -1, 300);
    chk("ovf_drain_strobe", {31'd0, overflow}, 32'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_clears_ovf", all_outs(), 32'd0);

    // Channel 0 leads, then strobes once more while full; reset at beat 500.
    for (int c = 0; c < NCH; c++) start_off[c] = (c == 0) ? 0 : 2;
    extra0_t  = 196;
    out_ready = 1'b1;
    stream();
    chk("ovf_fill_extra", {31'd0, overflow}, 32'd1);
    check_latency();
    drain(1'b0, 500, -1);
    chk("beat500_visible", {12'd0, out_data, out_ch, out_idx, out_last}, exp_beat(500));
    rst = 1'b1;
    tick();
    chk("reset_mid_drain", all_outs(), 32'd0);
    rst       = 1'b0;
    extra0_t  = -1;
    saw_valid = 1'b0;
    for (int c = 0; c < NCH; c++) start_off[c] = 0;
    repeat (20) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    chk("idle_after_reset", {31'd0, saw_valid}, 32'd0);

    // Fresh frame with signed extremes on channel 5.
    edge_vals = 1'b1;
    stream();
    check_latency();
    drain(1'b0, -1, -1);
    chk("ovf_after_clean", {31'd0, overflow}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
